cic_decimator: RTL and testbench

Single-channel CIC decimation filter placed directly downstream of the quadrature mixer; one instance each for the I (cosine_out) and Q (sine_out) paths. It takes one signed mixer product per valid clock, integrates at full rate, decimates by 2^DECIM_LOG2 and combs at the low rate. It emits one truncated output sample with a single-cycle valid strobe per block.

---
 rtl/cic_pkg.sv | 15 +
 rtl/cic_comb_stage.sv | 41 ++++
 rtl/cic_decimator.sv | 138 +++++++++++++
 tb/tb_cic_decimator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and width helper for the CIC decimator and the I/Q top level
// that instantiates one decimator per mixer output.
package cic_pkg;

    localparam int CIC_WIDTH      = 12;
    localparam int CIC_STAGES     = 4;
    localparam int CIC_DECIM_LOG2 = 6;
    localparam int CIC_OUT_WIDTH  = 16;

    // Worst-case register growth of an N-stage CIC with R = 2^decim_log2.
    function automatic int cic_acc_width(input int width, input int stages, input int decim_log2);
        return width + stages * decim_log2;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One low-rate comb section: c <= din - d, d <= din, both only when enabled.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int ACC_WIDTH = 36
) (
    input  logic                 clock,
    input  logic                 clock_areset_n,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0] dout
);

    logic [ACC_WIDTH-1:0] c_q;
    logic [ACC_WIDTH-1:0] c_d;
    logic [ACC_WIDTH-1:0] d_q;
    logic [ACC_WIDTH-1:0] d_d;

    // Modulo subtraction; integrator wrap cancels out here.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (en) begin
            c_d = din - d_q;
            d_d = din;
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            c_q <= '0;
            d_q <= '0;
        end else begin
            c_q <= c_d;
            d_q <= d_d;
        end
    end

    assign dout = c_q;

endmodule

// File: rtl/cic_decimator.sv
// Single-channel CIC decimator: full-rate integrators, decimate by 2^DECIM_LOG2,
// pipelined low-rate combs, truncated output with a one-cycle valid strobe.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int WIDTH      = CIC_WIDTH,
    parameter int STAGES     = CIC_STAGES,
    parameter int DECIM_LOG2 = CIC_DECIM_LOG2,
    parameter int OUT_WIDTH  = CIC_OUT_WIDTH
) (
    input  logic                        clock,
    input  logic                        clock_areset_n,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     data_in,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    localparam int ACC_WIDTH = cic_acc_width(WIDTH, STAGES, DECIM_LOG2);
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    logic [ACC_WIDTH-1:0] sample_ext;
    logic [ACC_WIDTH-1:0] integ_tap [STAGES];
    logic [ACC_WIDTH-1:0] comb_in   [STAGES];
    logic [ACC_WIDTH-1:0] comb_out  [STAGES];
    logic [ACC_WIDTH-1:0] comb_last;

    logic [DECIM_LOG2-1:0] count_q;
    logic [DECIM_LOG2-1:0] count_d;
    logic                  dec_stb_q;
    logic                  dec_stb_d;
    logic [STAGES-1:0]     fire;
    logic [STAGES-1:0]     fire_q;
    logic [STAGES-1:0]     fire_d;

    assign sample_ext = {{(ACC_WIDTH-WIDTH){data_in[WIDTH-1]}}, data_in};

    // Each integrator adds the registered value of the stage before it, so
    // stage k lags the input by k accepted samples.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_integ
        logic [ACC_WIDTH-1:0] integ_q;
        logic [ACC_WIDTH-1:0] integ_d;
        logic [ACC_WIDTH-1:0] addend;

        if (gi == 0) begin : g_first
            assign addend = sample_ext;
        end else begin : g_chain
            assign addend = integ_tap[gi-1];
        end

        always_comb begin
            integ_d = integ_q;
            if (in_valid) begin
                integ_d = integ_q + addend;
            end
        end

        always_ff @(posedge clock or negedge clock_areset_n) begin
            if (!clock_areset_n) begin
                integ_q <= '0;
            end else begin
                integ_q <= integ_d;
            end
        end

        assign integ_tap[gi] = integ_q;
    end

    always_comb begin
        count_d   = count_q;
        dec_stb_d = 1'b0;
        if (in_valid) begin
            count_d   = count_q + 1'b1;
            dec_stb_d = (count_q == CNT_LAST);
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            count_q   <= '0;
            dec_stb_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            dec_stb_q <= dec_stb_d;
        end
    end

    // fire[k] enables comb stage k; the token walks one stage per clock.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_fire
        if (gi == 0) begin : g_head
            assign fire[gi] = dec_stb_q;
        end else begin : g_walk
            assign fire[gi] = fire_q[gi-1];
        end
    end

    always_comb begin
        fire_d = fire;
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            fire_q <= '0;
        end else begin
            fire_q <= fire_d;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
        if (gi == 0) begin : g_src
            assign comb_in[gi] = integ_tap[STAGES-1];
        end else begin : g_link
            assign comb_in[gi] = comb_out[gi-1];
        end

        cic_comb_stage #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_comb (
            .clock          (clock),
            .clock_areset_n (clock_areset_n),
            .en             (fire[gi]),
            .din            (comb_in[gi]),
            .dout           (comb_out[gi])
        );
    end

    // The last comb register only changes when its stage fires, so it holds
    // the sample between strobes without a separate output register.
    assign comb_last = comb_out[STAGES-1];
    assign out_data  = comb_last[ACC_WIDTH-1 -: OUT_WIDTH];
    assign out_valid = fire_q[STAGES-1];

    if (ACC_WIDTH > OUT_WIDTH) begin : g_trunc
        logic unused_trunc_bits;
        assign unused_trunc_bits = ^comb_last[ACC_WIDTH-OUT_WIDTH-1:0];
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: stimulus pushes expected samples and
// strobe times, a negedge monitor pops and compares on every out_valid.
module tb_cic_decimator;
    import cic_pkg::*;

    localparam int W  = CIC_WIDTH;
    localparam int N  = CIC_STAGES;
    localparam int DL = CIC_DECIM_LOG2;
    localparam int OW = CIC_OUT_WIDTH;
    localparam int AW = W + N * DL;
    localparam int R  = 1 << DL;
    localparam longint MASK = (64'sd1 <<< AW) - 64'sd1;

    logic                 clock = 1'b0;
    logic                 clock_areset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [W-1:0]  data_in = '0;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;

    cic_decimator #(
        .WIDTH      (W),
        .STAGES     (N),
        .DECIM_LOG2 (DL),
        .OUT_WIDTH  (OW)
    ) dut (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .in_valid       (in_valid),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_data       (out_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        longint val;
        int     cyc;
        bit     hand;
        longint hv;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sample-level CIC model: integrate modulo 2^AW, comb once per block.
    longint m_integ [N];
    longint m_d     [N];
    int     m_cnt;
    int     blk_since;
    bit     hand_on;
    longint hand_v;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_integ[k] = 0;
            m_d[k]     = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_accept(input longint x, input int edge_no);
        longint v;
        longint c;
        logic [AW-1:0] t;
        logic signed [OW-1:0] o;
        exp_t e;
        for (int k = N - 1; k >= 1; k--) begin
            m_integ[k] = (m_integ[k] + m_integ[k-1]) & MASK;
        end
        m_integ[0] = (m_integ[0] + x) & MASK;
        if (m_cnt == R - 1) begin
            v = m_integ[N-1];
            for (int k = 0; k < N; k++) begin
                c = (v - m_d[k]) & MASK;
                m_d[k] = v;
                v = c;
            end
            t = v[AW-1:0];
            o = t[AW-1 -: OW];
            e.val  = o;
            e.cyc  = edge_no + N;   // strobe visible right after edge E+N
            e.hand = hand_on && (blk_since >= N);
            e.hv   = hand_v;
            exp_q.push_back(e);
            blk_since++;
        end
        m_cnt = (m_cnt + 1) % R;
    endtask

    task automatic step(input logic v, input logic signed [W-1:0] d);
        in_valid = v;
        data_in  = d;
        @(posedge clock);
        #1;
        if (v) model_accept(longint'(d), cyc);
    endtask

    task automatic run_blocks(input int nblk, input bit toggle, input logic signed [W-1:0] d,
                              input bit hand, input longint hv);
        hand_on   = hand;
        hand_v    = hv;
        blk_since = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < R; i++) begin
                step(1'b1, d);
                if (toggle) step(1'b0, d);
            end
        end
        $display("run: %0d blocks data=%0d toggle=%0d done at cycle %0d", nblk, d, toggle, cyc);
    endtask

    // Monitor
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (clock_areset_n && out_valid) begin
                check("strobe_spacing", longint'(prev), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out: cycle=%0d data=%0d expected=%0d", cyc, out_data, e.val);
                    check("out_data", longint'(out_data), e.val);
                    check("latency", cyc, e.cyc);
                    if (e.hand) check("settled_value", longint'(out_data), e.hv);
                end
            end
            prev = out_valid;
        end
    end

    initial begin
        logic signed [W-1:0] r;
        model_reset();
        hand_on = 1'b0;
        hand_v  = 0;
        blk_since = 0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_data", longint'(out_data), 0);
        @(negedge clock);
        clock_areset_n = 1'b1;

        run_blocks(8, 1'b0, 12'sd1, 1'b1, 16);
        run_blocks(8, 1'b0, 12'sd2047, 1'b1, 32752);
        run_blocks(8, 1'b0, -12'sd2048, 1'b1, -32768);
        run_blocks(8, 1'b1, 12'sd100, 1'b1, 1600);

        hand_on = 1'b0;
        for (int i = 0; i < 20 * R; i++) begin
            r = W'($urandom());
            step(1'b1, r);
        end

        // Reset with the block partially filled and the comb pipeline idle
        for (int i = 0; i < 30; i++) step(1'b1, 12'sd500);
        in_valid = 1'b0;
        clock_areset_n = 1'b0;
        #1;
        check("midblock_reset_valid", longint'(out_valid), 0);
        check("midblock_reset_data", longint'(out_data), 0);
        check("midblock_reset_queue", exp_q.size(), 0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        clock_areset_n = 1'b1;
        run_blocks(6, 1'b0, 12'sd1, 1'b1, 16);

        // Reset while the comb pipeline is processing a block
        hand_on = 1'b0;
        for (int i = 0; i < R; i++) step(1'b1, 12'sd300);
        step(1'b0, 12'sd0);
        clock_areset_n = 1'b0;
        #1;
        check("comb_reset_valid", longint'(out_valid), 0);
        check("comb_reset_data", longint'(out_data), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        clock_areset_n = 1'b1;
        run_blocks(6, 1'b0, 12'sd100, 1'b1, 1600);

        in_valid = 1'b0;
        repeat (N + 4) @(posedge clock);
        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
